cb_control_sequencer: RTL and testbench
=======================================

# cb_control_sequencer

Control sequencer for the 8-bit CPU datapath. It steps a six-state T-state ring and decodes the instruction register opcode into the load/output/increment strobes that drive the program counter, MAR, RAM, IR, A/B registers, ALU and output register. Every `cb_register` instance in the datapath takes its `load` from this block. The sequencer is the sole owner of the shared 8-bit bus drive enables.

## Interface
Parameters:
- `OP_LDA`, 4'h0, opcode for load A from memory
- `OP_ADD`, 4'h1, opcode for A = A + mem
- `OP_SUB`, 4'h2, opcode for A = A - mem
- `OP_OUT`, 4'h3, opcode for output register = A
- `OP_HLT`, 4'hF, opcode for halt

Ports:
- `clk` in 1: single clock; all state changes on rising edge
- `clear` in 1: synchronous, active-high reset
- `step` in 1: single-step advance qualifier; ignored unless `SINGLE_STEP_EN` is defined
- `opcode` in 4: IR[7:4]
- `t_state` out 6: one-hot T1..T6; 6'b0 when halted
- `pc_out`, `pc_inc`, `mar_load`, `ram_out`, `ir_load`, `ir_out` out 1 each: datapath strobes
- `a_load`, `a_out`, `b_load`, `alu_out`, `alu_sub`, `out_load` out 1 each: datapath strobes
- `halted` out 1: high while in the HALT state

## Operation
- States: T1..T6 (one-hot ring) plus HALT. Transitions: T1→T2→…→T6→T1.
- HLT exception: T4 with `opcode==OP_HLT` goes to HALT. HALT is held until `clear`.
- Strobes are Moore-style decodes of the current state and `opcode`. They are valid for the whole cycle, and the target registers capture at the next rising edge.
- Fetch, for all opcodes:
  - T1: `pc_out`, `mar_load`
  - T2: `pc_inc`
  - T3: `ram_out`, `ir_load`
- Execute:
  - LDA: T4 `ir_out`+`mar_load`; T5 `ram_out`+`a_load`; T6 none.
  - ADD: T4 `ir_out`+`mar_load`; T5 `ram_out`+`b_load`; T6 `alu_out`+`a_load`.
  - SUB: same as ADD, with `alu_sub` also asserted in T6.
  - OUT: T4 `a_out`+`out_load`; T5 and T6 none.
  - HLT: T4 none, then enter HALT.
  - Any other opcode is a NOP: T4–T6 none, and the ring completes normally.
- Bus-driver exclusivity: at most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out` is high in any cycle. Violation is a design error.
- `opcode` is only decoded in T4–T6. Its value in T1–T3 has no effect.

## Timing
- Reset: a rising edge with `clear`=1 forces T1 and `halted`=0, regardless of current state, including mid-instruction and HALT.
- Outputs in the cycle after reset: `t_state`=6'b000001, `pc_out`=1, `mar_load`=1, all other strobes 0, `halted`=0.
- Instruction length: fixed 6 cycles, with no early exit for LDA, OUT or NOP.
- HLT timing: `halted` rises in the cycle after T4, i.e. 4 cycles after the instruction's T1. In HALT, all strobes are 0 and `t_state`=0.
- `clear` and `step` high together: `clear` wins.

## Configuration
- `SINGLE_STEP_EN` defined:
  - The state advances only on edges where `step`=1. Otherwise the state holds.
  - All strobes are ANDed with `step`, so a held state never re-loads a register or re-increments the PC.
  - `halted` and `t_state` are not gated.
  - `clear` is unaffected by `step`.
- `SINGLE_STEP_EN` undefined: `step` is ignored and the ring free-runs one state per clock.

## Test plan
- Reset and fetch: assert `clear` for 1 cycle, `opcode`=4'h0. Required: `t_state` goes 01→02→04 over three cycles; `pc_out`/`mar_load` in T1, `pc_inc` in T2, `ram_out`/`ir_load` in T3.
- SUB execute: `opcode`=4'h2. Required: T5 `b_load`=1 only; T6 `alu_out`=`a_load`=`alu_sub`=1; returns to `t_state`=01 on the 7th cycle.
- Halt: `opcode`=4'hF. Required: `halted`=1 and `t_state`=0 from cycle 5 on; all strobes 0 for 20 further cycles. Then `clear`=1 returns to T1 with `halted`=0.
- Mid-instruction reset: ADD with `clear` asserted during T5. Required: the next cycle is T1 and `b_load` never asserts.
- Bus exclusivity: sweep all 16 opcodes for one full instruction each. Required: the one-hot check on bus drivers holds every cycle; opcodes 4..E show no strobes in T4–T6.
- `SINGLE_STEP_EN` build: `step`=0 for 5 cycles in T2. Required: `t_state` stays 02 and `pc_inc` stays 0. One `step` pulse then gives `pc_inc`=1 for exactly 1 cycle and `t_state`=04 afterwards.

Source files
------------

// File: rtl/cb_control_sequencer.sv
// cb_control_sequencer
// T-state sequencer for the 8-bit CPU datapath. A six-state ring (T1..T6)
// plus a HALT state. The current state and the opcode are decoded into the
// load/output/increment strobes that drive the datapath registers and the
// shared 8-bit bus.
//
// Optional build macro: SINGLE_STEP_EN
//   defined   - the state advances only on edges where step=1, and every
//               strobe is ANDed with step. halted and t_state are not gated.
//   undefined - step is ignored and the ring advances one state per clock.
//
// Ports:
//   clk      in  : rising-edge clock
//   clear    in  : synchronous active-high reset to T1; overrides step
//   step     in  : single-step qualifier (used only with SINGLE_STEP_EN)
//   opcode   in  : IR[7:4], decoded only in T4..T6
//   t_state  out : one-hot T1..T6, all zero while halted
//   pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
//   a_load, a_out, b_load, alu_out, alu_sub, out_load  out : datapath strobes
//   halted   out : high while in HALT
module cb_control_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'h3,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       step,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted
);

  localparam logic [2:0] S_T1   = 3'd0;
  localparam logic [2:0] S_T2   = 3'd1;
  localparam logic [2:0] S_T3   = 3'd2;
  localparam logic [2:0] S_T4   = 3'd3;
  localparam logic [2:0] S_T5   = 3'd4;
  localparam logic [2:0] S_T6   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic        advance;
  logic        strobe_en;
  logic [11:0] strobe_raw;

`ifdef SINGLE_STEP_EN
  assign advance   = step;
  assign strobe_en = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign advance     = 1'b1;
  assign strobe_en   = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    if (advance) begin
      case (state_reg)
        S_T1:    state_next = S_T2;
        S_T2:    state_next = S_T3;
        S_T3:    state_next = S_T4;
        S_T4:    state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state_next = S_T6;
        S_T6:    state_next = S_T1;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_T1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg <= S_T1;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobe bit order in strobe_raw, MSB first:
  // pc_out pc_inc mar_load ram_out ir_load ir_out a_load a_out b_load alu_out alu_sub out_load
  always_comb begin
    logic is_mem;
    logic is_alu;
    is_mem     = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
    is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB);
    strobe_raw = '0;
    case (state_reg)
      S_T1: strobe_raw = 12'b1010_0000_0000;           // pc_out, mar_load
      S_T2: strobe_raw = 12'b0100_0000_0000;           // pc_inc
      S_T3: strobe_raw = 12'b0001_1000_0000;           // ram_out, ir_load
      S_T4: begin
        if (is_mem)
          strobe_raw = 12'b0010_0100_0000;             // ir_out, mar_load
        else if (opcode == OP_OUT)
          strobe_raw = 12'b0000_0001_0001;             // a_out, out_load
      end
      S_T5: begin
        if (opcode == OP_LDA)
          strobe_raw = 12'b0001_0010_0000;             // ram_out, a_load
        else if (is_alu)
          strobe_raw = 12'b0001_0000_1000;             // ram_out, b_load
      end
      S_T6: begin
        if (is_alu)
          strobe_raw = {10'b00_0000_1001, (opcode == OP_SUB), 1'b0}; // alu_out, a_load
      end
      default: strobe_raw = '0;
    endcase
  end

  assign {pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
          a_load, a_out, b_load, alu_out, alu_sub, out_load} =
         strobe_raw & {12{strobe_en}};

  assign halted  = (state_reg == S_HALT);
  assign t_state = (state_reg <= S_T6) ? (6'b000001 << state_reg) : 6'b000000;

endmodule

// File: tb/tb_cb_control_sequencer.sv
// Scoreboard bench for cb_control_sequencer. The stimulus process keeps an
// instruction-level model (position within the 6-cycle instruction plus a
// halted flag) and pushes the expected outputs for each cycle into a queue;
// the monitor pops and compares on the falling edge.
module tb_cb_control_sequencer;

`ifdef SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       step = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;

  cb_control_sequencer dut (
    .clk(clk), .clear(clear), .step(step), .opcode(opcode), .t_state(t_state),
    .pc_out(pc_out), .pc_inc(pc_inc), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  logic [18:0] exp_q[$];

  // model state: position within the instruction (0 = T1) and halt flag
  int phase = 0;
  bit hlt = 1'b0;

  // Expected {halted, t_state, pc_out..out_load} for one cycle.
  function automatic logic [18:0] model_out(int ph, bit h, logic [3:0] op, logic stp);
    logic [11:0] s;
    bit is_mem;
    bit is_alu;
    s = '0;
    if (h) return {1'b1, 6'b0, 12'b0};
    is_mem = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
    is_alu = (op == 4'h1) || (op == 4'h2);
    // bits: 11 pc_out 10 pc_inc 9 mar_load 8 ram_out 7 ir_load 6 ir_out
    //        5 a_load  4 a_out  3 b_load   2 alu_out 1 alu_sub 0 out_load
    case (ph)
      0: begin s[11] = 1; s[9] = 1; end
      1: s[10] = 1;
      2: begin s[8] = 1; s[7] = 1; end
      3: begin
        if (is_mem) begin s[6] = 1; s[9] = 1; end
        else if (op == 4'h3) begin s[4] = 1; s[0] = 1; end
      end
      4: begin
        if (op == 4'h0) begin s[8] = 1; s[5] = 1; end
        else if (is_alu) begin s[8] = 1; s[3] = 1; end
      end
      5: begin
        if (is_alu) begin s[2] = 1; s[5] = 1; end
        if (op == 4'h2) s[1] = 1;
      end
      default: s = '0;
    endcase
    if (SS && !stp) s = '0;
    return {1'b0, 6'b000001 << ph, s};
  endfunction

  task automatic cyc(input logic clr, input logic [3:0] op, input logic stp);
    clear  = clr;
    opcode = op;
    step   = stp;
    exp_q.push_back(model_out(phase, hlt, op, stp));
    @(posedge clk);
    #1;
    if (clr) begin
      phase = 0;
      hlt   = 1'b0;
    end else if ((!SS || stp) && !hlt) begin
      if (phase == 3 && op == 4'hF) hlt = 1'b1;
      else phase = (phase + 1) % 6;
    end
  endtask

  // Monitor: compare outputs to the scoreboard every cycle with an entry.
  always @(negedge clk) begin
    logic [18:0] got;
    logic [18:0] exp;
    got = {halted, t_state, pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load};
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      cycle_no++;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs cycle %0d: got=%05h required=%05h", cycle_no, got, exp);
      end else begin
        $display("cycle %0d clear=%b step=%b op=%h t_state=%b strobes=%012b halted=%b",
                 cycle_no, clear, step, opcode, t_state, got[11:0], halted);
      end
      checks++;
      if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
        errors++;
        $display("FAIL bus_excl cycle %0d: drivers=%05b required at most one high",
                 cycle_no, {pc_out, ram_out, ir_out, a_out, alu_out});
      end
    end
  end

  initial begin
    // initial reset edge (state unknown before it, so no expectation yet)
    clear = 1'b1;
    @(posedge clk);
    #1;
    phase = 0;
    hlt   = 1'b0;

    // fetch + LDA
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 1'b1);
    // SUB, then one more cycle to see return to T1
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'h2, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h2, 1'b1);   // finish that instr
    // HLT: 4 cycles to T4, then 20+ halted cycles, then clear
    for (int i = 0; i < 25; i++) cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b1, 4'hF, 1'b1);
    // ADD, reset at the edge that would enter T5 so b_load never shows
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h1, 1'b1);
    cyc(1'b1, 4'h1, 1'b1);
    // ADD, reset while sitting in T5
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1, 1'b1);
    cyc(1'b1, 4'h1, 1'b1);
    // sweep all opcodes; HLT needs a clear afterwards
    for (int op = 0; op < 16; op++) begin
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'(op), 1'b1);
      if (op == 15) cyc(1'b1, 4'h0, 1'b1);
    end
    // single-step hold in T2
    if (SS) begin
      cyc(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b0);
      cyc(1'b0, 4'h0, 1'b1);
      cyc(1'b0, 4'h0, 1'b0);
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0));
      if (hlt && $urandom_range(0, 7) == 0) cyc(1'b1, 4'h0, 1'b1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
